fpr_writeback_queue: RTL and testbench

//  Write-side companion of the FP register file. Buffers FP results (dest reg + 32-bit value) from the

---
 rtl/fpr_writeback_queue.sv | 129 ++++++++++++
 tb/tb_fpr_writeback_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fpr_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : fpr_writeback_queue
// Purpose  : Write-side companion of the FP register file. Results from the
//            multi-cycle FP datapath are buffered in an in-order FIFO and
//            drained one per cycle onto the registered FPR write port. The
//            pending-write check lets decode stall on FP RAW hazards.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   system clock, all state updates on posedge
//   reset      in   asynchronous active-low reset
//   enq_valid  in   FP result offered this cycle
//   enq_ready  out  queue can accept (== !full)
//   enq_rd     in   destination FP register of the offered result
//   enq_data   in   offered result value
//   wr_stall   in   write port unavailable, hold the head entry
//   regWr      out  registered write enable to the FPR file
//   Rw         out  registered write address to the FPR file
//   busW       out  registered write data to the FPR file
//   chk_rs     in   source register 1 being decoded
//   chk_rt     in   source register 2 being decoded
//   pend_rs    out  chk_rs has a write not yet committed
//   pend_rt    out  chk_rt has a write not yet committed
//   count      out  number of valid entries, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
// ============================================================================
module fpr_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [0:4]        enq_rd,
  input  logic [0:31]       enq_data,
  input  logic              wr_stall,
  output logic              regWr,
  output logic [0:4]        Rw,
  output logic [0:31]       busW,
  input  logic [0:4]        chk_rs,
  input  logic [0:4]        chk_rt,
  output logic              pend_rs,
  output logic              pend_rt,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = (ADDR_W)'(1);

  logic [0:4]        rd_mem   [DEPTH];
  logic [0:31]       data_mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic enq;
  logic pop;

  // Status is decoded purely from count.
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign enq_ready = !full;

  // Enqueue is blocked whenever full, even if a pop frees a slot this cycle.
  assign enq = enq_valid && !full;
  assign pop = !empty && !wr_stall;

  // Payload storage needs no reset: the valid bits qualify every read.
  always_ff @(posedge clk) begin
    if (enq) begin
      rd_mem[wr_ptr]   <= enq_rd;
      data_mem[wr_ptr] <= enq_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
      regWr  <= 1'b0;
      Rw     <= '0;
      busW   <= '0;
    end else begin
      // enq and pop never target the same slot: that would need the queue to
      // be both full (enq blocked) or empty (pop blocked).
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_ONE;
        regWr         <= 1'b1;
        Rw            <= rd_mem[rd_ptr];
        busW          <= data_mem[rd_ptr];
      end else begin
        regWr         <= 1'b0;
      end

      if (enq) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PTR_ONE;
      end

      case ({enq, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // A write is still pending while queued or while it sits on the output
  // register waiting for the FPR file to capture it on the falling edge.
  always_comb begin
    pend_rs = regWr && (Rw == chk_rs);
    pend_rt = regWr && (Rw == chk_rt);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (rd_mem[i] == chk_rs)) pend_rs = 1'b1;
      if (valid[i] && (rd_mem[i] == chk_rt)) pend_rt = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpr_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpr_writeback_queue
// Purpose  : Self-checking bench for fpr_writeback_queue. A queue-based
//            reference model predicts status, write-port and pending outputs.
// Revision : 1.0  initial release
// ============================================================================
module tb_fpr_writeback_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  typedef struct packed {
    logic [0:4]  rd;
    logic [0:31] data;
  } ent_t;

  logic            clk;
  logic            reset;
  logic            enq_valid;
  logic            enq_ready;
  logic [0:4]      enq_rd;
  logic [0:31]     enq_data;
  logic            wr_stall;
  logic            regWr;
  logic [0:4]      Rw;
  logic [0:31]     busW;
  logic [0:4]      chk_rs;
  logic [0:4]      chk_rt;
  logic            pend_rs;
  logic            pend_rt;
  logic [ADDR_W:0] count;
  logic            full;
  logic            empty;

  fpr_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_rd    (enq_rd),
    .enq_data  (enq_data),
    .wr_stall  (wr_stall),
    .regWr     (regWr),
    .Rw        (Rw),
    .busW      (busW),
    .chk_rs    (chk_rs),
    .chk_rt    (chk_rt),
    .pend_rs   (pend_rs),
    .pend_rt   (pend_rt),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  ent_t        q[$];
  logic        m_wr;
  logic [0:4]  m_rw;
  logic [0:31] m_busw;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_pend(input logic [0:4] r);
    logic hit;
    hit = m_wr && (m_rw == r);
    foreach (q[i]) if (q[i].rd == r) hit = 1'b1;
    return hit;
  endfunction

  // Compare every output against the model for the inputs now applied.
  task automatic check_all();
    check("count",     64'(count),     64'(q.size()));
    check("full",      64'(full),      64'(q.size() == DEPTH));
    check("empty",     64'(empty),     64'(q.size() == 0));
    check("enq_ready", 64'(enq_ready), 64'(q.size() != DEPTH));
    check("regWr",     64'(regWr),     64'(m_wr));
    if (m_wr) begin
      check("Rw",   64'(Rw),   64'(m_rw));
      check("busW", 64'(busW), 64'(m_busw));
    end
    check("pend_rs", 64'(pend_rs), 64'(model_pend(chk_rs)));
    check("pend_rt", 64'(pend_rt), 64'(model_pend(chk_rt)));
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model
  // to what the coming rising edge should produce.
  task automatic step(input logic v, input logic [0:4] rd, input logic [0:31] d,
                      input logic st, input logic [0:4] rs, input logic [0:4] rt);
    @(negedge clk);
    enq_valid = v;
    enq_rd    = rd;
    enq_data  = d;
    wr_stall  = st;
    chk_rs    = rs;
    chk_rt    = rt;
    #1;
    check_all();
    if (q.size() > 0 && !st) begin
      m_wr   = 1'b1;
      m_rw   = q[0].rd;
      m_busw = q[0].data;
      void'(q.pop_front());
    end else begin
      m_wr = 1'b0;
    end
    if (v && q.size() + (m_wr ? 1 : 0) < DEPTH) q.push_back('{rd: rd, data: d});
  endtask

  // Pulse reset low between edges and confirm it acts immediately.
  task automatic pulse_reset();
    @(negedge clk);
    enq_valid = 1'b0;
    wr_stall  = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_regWr", 64'(regWr), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_Rw",    64'(Rw),    64'd0);
    check("rst_busW",  64'(busW),  64'd0);
    q.delete();
    m_wr = 1'b0; m_rw = '0; m_busw = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    enq_valid = 1'b0; enq_rd = '0; enq_data = '0;
    wr_stall = 1'b0; chk_rs = '0; chk_rt = '0;
    m_wr = 1'b0; m_rw = '0; m_busw = '0;
    repeat (2) @(negedge clk);
    #1;
    check("init_count", 64'(count), 64'd0);
    check("init_regWr", 64'(regWr), 64'd0);
    check("init_empty", 64'(empty), 64'd1);
    check("init_Rw",    64'(Rw),    64'd0);
    check("init_busW",  64'(busW),  64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single write latency and pending window
    step(1, 5, 32'h3F80_0000, 0, 5, 0);
    step(0, 0, 0, 0, 5, 0);
    step(0, 0, 0, 0, 5, 0);
    step(0, 0, 0, 0, 5, 0);

    // Fill while stalled, fifth offer rejected, then drain
    for (int i = 1; i <= 4; i++) step(1, 5'(i), 32'(i), 1, 5'(i), 9);
    step(1, 9, 32'h99, 1, 9, 4);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 9, 5'(i + 1));

    // Continuous stream of ten with drain, pointers wrap
    for (int i = 0; i < 10; i++) step(1, 5'(i), 32'(i * 32'h11), 0, 5'(i), 5'(i ? i - 1 : 0));
    step(0, 0, 0, 0, 9, 8);
    step(0, 0, 0, 0, 0, 0);

    // Simultaneous enqueue and pop at count 2
    step(1, 3, 32'h30, 1, 3, 0);
    step(1, 4, 32'h40, 1, 4, 3);
    step(1, 6, 32'h60, 0, 6, 4);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 6, 4);

    // Same destination twice
    step(1, 7, 32'hA, 0, 0, 7);
    step(1, 7, 32'hB, 0, 0, 7);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 7);

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) step(1, 5'(10 + i), 32'(i), 1, 10, 11);
    pulse_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 10, 12);

    // Randomized traffic with varying load/stall bias
    for (int blk = 0; blk < 8; blk++) begin
      int vp, sp;
      vp = $urandom_range(20, 95);
      sp = $urandom_range(0, 70);
      for (int c = 0; c < 50; c++) begin
        step(($urandom_range(0, 99) < vp), 5'($urandom_range(0, 7)), $urandom,
             ($urandom_range(0, 99) < sp), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      if (blk == 4) pulse_reset();
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 5'(i), 5'(i + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
